control_unit: RTL

- Multicycle FSM controller that drives every control wire of the existing MIPS-subset datapath (PC, IR, register bank, ALU, memory, write-back muxes).
- Takes the decoded opcode/funct from the instruction register and the ALU flags, and sequences fetch, decode, execute, memory and write-back.
- Sits beside the datapath inside cpu; it is the producer of the control bundle the datapath consumes.

---
 rtl/control_unit.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multicycle MIPS-subset controller: sequences fetch/decode/execute/mem/wb.
// Optional overflow trap enabled by defining OVERFLOW_TRAP_EN.
module control_unit #(
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PCwrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    RESET     = 5'd0,
    FETCH     = 5'd1,
    IR_LOAD   = 5'd2,
    DECODE    = 5'd3,
    EXEC_R    = 5'd4,
    WB_R      = 5'd5,
    EXEC_I    = 5'd6,
    WB_I      = 5'd7,
    MEM_ADDR  = 5'd8,
    MEM_READ  = 5'd9,
    WB_MEM    = 5'd10,
    MEM_WRITE = 5'd11,
    BRANCH    = 5'd12,
`ifdef OVERFLOW_TRAP_EN
    EXCEPT    = 5'd14,
`endif
    JUMP      = 5'd13
  } state_t;

  localparam logic [2:0] WAIT = 3'(MEM_WAIT);

  state_t     state;
  logic [2:0] cnt;
  logic       trap;
  logic       is_r, is_addi, is_mem;
  logic       is_br, is_j, op_ok;
  logic       r_ok;
  logic [2:0] r_aluop;

  assign is_r    = (OPCODE == 6'h00);
  assign is_addi = (OPCODE == 6'h08);
  assign is_mem  = (OPCODE == 6'h23) ||
                   (OPCODE == 6'h2B);
  assign is_br   = (OPCODE == 6'h04) ||
                   (OPCODE == 6'h05);
  assign is_j    = (OPCODE == 6'h02);
  assign op_ok   = is_r | is_addi | is_mem |
                   is_br | is_j;

  always_comb begin
    r_ok    = 1'b1;
    r_aluop = 3'b000;
    case (FUNCT)
      6'h20:   r_aluop = 3'b000;
      6'h22:   r_aluop = 3'b001;
      6'h24:   r_aluop = 3'b010;
      6'h25:   r_aluop = 3'b011;
      6'h2A:   r_aluop = 3'b100;
      default: r_ok    = 1'b0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q;

  // Overflow is only meaningful for signed add/sub and addi
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (state == EXEC_R) begin
      ovf_q <= Overflow &&
               (FUNCT == 6'h20 || FUNCT == 6'h22);
    end else if (state == EXEC_I) begin
      ovf_q <= Overflow;
    end
  end

  assign trap = ovf_q;
`else
  wire unused_ovf = Overflow;
  wire [1:0] unused_exc = EXC_VECTOR_SEL;

  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET;
      cnt   <= 3'd0;
    end else begin
      unique case (state)
        RESET:   state <= FETCH;
        FETCH: begin
          if (cnt == WAIT) begin
            cnt   <= 3'd0;
            state <= IR_LOAD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        IR_LOAD: state <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_r:    state <= EXEC_R;
            is_addi: state <= EXEC_I;
            is_mem:  state <= MEM_ADDR;
            is_br:   state <= BRANCH;
            is_j:    state <= JUMP;
            default: state <= FETCH;
          endcase
        end
        EXEC_R:  state <= r_ok ? WB_R : FETCH;
        EXEC_I:  state <= WB_I;
        WB_R, WB_I: begin
`ifdef OVERFLOW_TRAP_EN
          state <= trap ? EXCEPT : FETCH;
`else
          state <= FETCH;
`endif
        end
        MEM_ADDR: begin
          state <= (OPCODE == 6'h23) ?
                   MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          if (cnt == WAIT) begin
            cnt   <= 3'd0;
            state <= WB_MEM;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCwrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    RegDest    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 3'b000;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state_dbg  = state;
    unique case (state)
      IR_LOAD: begin
        IRWrite = 1'b1;
        PCwrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !op_ok;
        instr_done = !op_ok;
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = r_aluop;
        illegal_op = !r_ok;
        instr_done = !r_ok;
      end
      WB_R: begin
        RegWrite   = !trap;
        RegDest    = 1'b1;
        instr_done = !trap;
      end
      EXEC_I, MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      WB_I: begin
        RegWrite   = !trap;
        instr_done = !trap;
      end
      MEM_READ: IorD = 1'b1;
      WB_MEM: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 3'b001;
        PCSource   = 2'b01;
        PCwrite    = OPCODE[0] ? !Zero : Zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCSource   = 2'b10;
        PCwrite    = 1'b1;
        instr_done = 1'b1;
      end
`ifdef OVERFLOW_TRAP_EN
      EXCEPT: begin
        PCSource   = EXC_VECTOR_SEL;
        PCwrite    = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
